// File: rtl/i2c_passthru_pkg.sv
// Shared encodings for the I2C SDA pass-through direction controller.
package i2c_passthru_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WR_DATA,
    ST_WR_ACK,
    ST_RD_DATA,
    ST_RD_ACK,
    ST_WAIT_STOP,
    ST_ABORT
  } state_e;

  localparam logic DIR_M2S = 1'b0;
  localparam logic DIR_S2M = 1'b1;

  localparam logic [3:0] BIT_LAST_DATA = 4'd7;
  localparam logic [3:0] BIT_ACK       = 4'd8;

  // Which side owns SDA in a given state; ABORT keeps whatever was selected.
  function automatic logic dir_of(input state_e st, input logic cur_dir);
    case (st)
      ST_ADDR_ACK, ST_WR_ACK, ST_RD_DATA: dir_of = DIR_S2M;
      ST_ABORT:                           dir_of = cur_dir;
      default:                            dir_of = DIR_M2S;
    endcase
  endfunction

endpackage

// File: rtl/i2c_passthru_start_stop_det.sv
// START/STOP and SCL edge pulses, decoded against the previous-cycle SCL/SDA registers.
module i2c_passthru_start_stop_det
  import i2c_passthru_pkg::*;
(
  input  logic i_clk,
  input  logic i_rstn,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_start,
  output logic o_stop,
  output logic o_scl_rise,
  output logic o_scl_fall
);

  logic scl_q;
  logic sda_q;

  // History resets to the idle-bus level so release never looks like an edge.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      scl_q <= 1'b1;
      sda_q <= 1'b1;
    end else begin
      scl_q <= i_scl;
      sda_q <= i_sda;
    end
  end

  assign o_start    = scl_q & i_scl & sda_q & ~i_sda;
  assign o_stop     = scl_q & i_scl & ~sda_q & i_sda;
  assign o_scl_rise = ~scl_q & i_scl;
  assign o_scl_fall = scl_q & ~i_scl;

endmodule

// File: rtl/i2c_passthru_sda_dir_ctrl.sv
// Tracks I2C framing and selects which side drives SDA, with a release gap at every turnaround.
module i2c_passthru_sda_dir_ctrl
  import i2c_passthru_pkg::*;
#(
  parameter int F_REF_TURN = 4,
  parameter int WIDTH_TURN = 3
) (
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic       i_f_ref,
  input  logic       i_scl,
  input  logic       i_sda_m,
  input  logic       i_sda_s,
  input  logic       i_mismatch_m,
  input  logic       i_mismatch_s,
  output logic       o_dir,
  output logic       o_drive_en,
  output logic       o_busy,
  output logic       o_abort,
  output logic [3:0] o_bit_cnt
);

  localparam logic [WIDTH_TURN-1:0] TURN_LOAD = WIDTH_TURN'(F_REF_TURN);

  logic start, stop, scl_rise, scl_fall;

  i2c_passthru_start_stop_det u_det (
    .i_clk      (i_clk),
    .i_rstn     (i_rstn),
    .i_scl      (i_scl),
    .i_sda      (i_sda_m),
    .o_start    (start),
    .o_stop     (stop),
    .o_scl_rise (scl_rise),
    .o_scl_fall (scl_fall)
  );

  state_e                state_q, state_d;
  logic                  dir_q, dir_d;
  logic                  drive_en_q, drive_en_d;
  logic                  busy_q, busy_d;
  logic                  abort_q, abort_d;
  logic [3:0]            bit_cnt_q, bit_cnt_d;
  logic                  rw_q, rw_d;
  logic                  nack_q, nack_d;
  logic                  armed_q, armed_d;
  logic                  fref_q;
  logic [WIDTH_TURN-1:0] turn_q, turn_d;
  logic                  fref_rise;
  logic                  mismatch_hit;
  logic                  framing;

  assign fref_rise = i_f_ref & ~fref_q;
  assign framing   = (state_q != ST_IDLE) && (state_q != ST_ABORT);

  // Only the destination pad's detector matters, and only once SDA is really driven.
  assign mismatch_hit = framing && drive_en_q && (turn_q == '0) &&
                        ((dir_q == DIR_M2S) ? i_mismatch_s : i_mismatch_m);

  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    abort_d   = abort_q;
    bit_cnt_d = bit_cnt_q;
    rw_d      = rw_q;
    nack_d    = nack_q;
    armed_d   = armed_q;

    if (stop) begin
      state_d   = ST_IDLE;
      busy_d    = 1'b0;
      abort_d   = 1'b0;
      bit_cnt_d = '0;
      armed_d   = 1'b0;
    end else if (start) begin
      state_d   = ST_ADDR;
      busy_d    = 1'b1;
      abort_d   = 1'b0;
      bit_cnt_d = '0;
      armed_d   = 1'b0;
    end else if (mismatch_hit) begin
      state_d = ST_ABORT;
      abort_d = 1'b1;
    end else if (framing) begin
      if (scl_rise) begin
        armed_d = 1'b1;
        if (state_q == ST_ADDR && bit_cnt_q == BIT_LAST_DATA) begin
          rw_d = i_sda_m;
        end
        if (state_q == ST_ADDR_ACK && bit_cnt_q == BIT_ACK) begin
          nack_d = i_sda_s;
        end
        if (state_q == ST_RD_ACK && bit_cnt_q == BIT_ACK) begin
          nack_d = i_sda_m;
        end
      end else if (scl_fall && armed_q) begin
        // The SCL fall that completes a START is not a bit; armed_q filters it out.
        armed_d   = 1'b0;
        bit_cnt_d = (bit_cnt_q == BIT_ACK) ? '0 : bit_cnt_q + 4'd1;
        case (state_q)
          ST_ADDR:     if (bit_cnt_q == BIT_LAST_DATA) state_d = ST_ADDR_ACK;
          ST_ADDR_ACK: if (bit_cnt_q == BIT_ACK)
                         state_d = nack_q ? ST_WAIT_STOP : (rw_q ? ST_RD_DATA : ST_WR_DATA);
          ST_WR_DATA:  if (bit_cnt_q == BIT_LAST_DATA) state_d = ST_WR_ACK;
          ST_WR_ACK:   if (bit_cnt_q == BIT_ACK) state_d = ST_WR_DATA;
          ST_RD_DATA:  if (bit_cnt_q == BIT_LAST_DATA) state_d = ST_RD_ACK;
          ST_RD_ACK:   if (bit_cnt_q == BIT_ACK)
                         state_d = nack_q ? ST_WAIT_STOP : ST_RD_DATA;
          default:     state_d = state_q;
        endcase
      end
    end

    dir_d = dir_of(state_d, dir_q);

    if (dir_d != dir_q) begin
      turn_d = TURN_LOAD;
    end else if (turn_q != '0 && fref_rise) begin
      turn_d = turn_q - 1'b1;
    end else begin
      turn_d = turn_q;
    end

    drive_en_d = (state_d != ST_ABORT) && (turn_d == '0);
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q    <= ST_IDLE;
      dir_q      <= DIR_M2S;
      drive_en_q <= 1'b0;
      busy_q     <= 1'b0;
      abort_q    <= 1'b0;
      bit_cnt_q  <= '0;
      rw_q       <= 1'b0;
      nack_q     <= 1'b0;
      armed_q    <= 1'b0;
      fref_q     <= 1'b0;
      turn_q     <= '0;
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      drive_en_q <= drive_en_d;
      busy_q     <= busy_d;
      abort_q    <= abort_d;
      bit_cnt_q  <= bit_cnt_d;
      rw_q       <= rw_d;
      nack_q     <= nack_d;
      armed_q    <= armed_d;
      fref_q     <= i_f_ref;
      turn_q     <= turn_d;
    end
  end

  assign o_dir      = dir_q;
  assign o_drive_en = drive_en_q;
  assign o_busy     = busy_q;
  assign o_abort    = abort_q;
  assign o_bit_cnt  = bit_cnt_q;

endmodule

// File: tb/tb_i2c_passthru_sda_dir_ctrl.sv
// Bench for i2c_passthru_sda_dir_ctrl: bus-level transactions against a bit-ownership model.
module tb_i2c_passthru_sda_dir_ctrl;

  localparam int F_REF_TURN = 4;
  localparam int WIDTH_TURN = 3;
  localparam int HALF       = 40;

  logic       clk   = 1'b0;
  logic       rstn  = 1'b0;
  logic       f_ref = 1'b0;
  logic       scl   = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_s = 1'b1;
  logic       mm_m  = 1'b0;
  logic       mm_s  = 1'b0;
  logic       dir, de, busy, abort;
  logic [3:0] bcnt;

  int errors = 0;
  int checks = 0;

  int   turn_log[$];
  int   ep_cnt    = 0;
  logic fref_prev = 1'b0;
  logic de_prev   = 1'b0;

  bit         owners[$];
  bit         vals[$];
  int         exp_turns;
  logic [7:0] xdata[4];
  bit         xack[4];

  i2c_passthru_sda_dir_ctrl #(
    .F_REF_TURN (F_REF_TURN),
    .WIDTH_TURN (WIDTH_TURN)
  ) dut (
    .i_clk        (clk),
    .i_rstn       (rstn),
    .i_f_ref      (f_ref),
    .i_scl        (scl),
    .i_sda_m      (sda_m),
    .i_sda_s      (sda_s),
    .i_mismatch_m (mm_m),
    .i_mismatch_s (mm_s),
    .o_dir        (dir),
    .o_drive_en   (de),
    .o_busy       (busy),
    .o_abort      (abort),
    .o_bit_cnt    (bcnt)
  );

  always #5 clk = ~clk;

  initial begin : fref_gen
    forever begin
      repeat ($urandom_range(1, 4)) @(posedge clk);
      #1 f_ref = ~f_ref;
    end
  end

  // Counts reference rising edges seen while drive is released; logs one count per release episode.
  initial begin : turn_mon
    forever begin
      @(negedge clk);
      if (!de && f_ref && !fref_prev) ep_cnt++;
      if (de && !de_prev) turn_log.push_back(ep_cnt);
      if (de) ep_cnt = 0;
      fref_prev = f_ref;
      de_prev   = de;
    end
  end

  task automatic clk_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Bus-level model: who owns each bit of the transaction and the value on the wire.
  task automatic build_xfer(input logic [7:0] ab, input bit anack, input int nb);
    bit prev;
    owners.delete();
    vals.delete();
    for (int i = 7; i >= 0; i--) begin
      owners.push_back(1'b0);
      vals.push_back(ab[i]);
    end
    owners.push_back(1'b1);
    vals.push_back(anack);
    if (!anack) begin
      for (int b = 0; b < nb; b++) begin
        for (int i = 7; i >= 0; i--) begin
          owners.push_back(ab[0]);
          vals.push_back(xdata[b][i]);
        end
        owners.push_back(!ab[0]);
        vals.push_back(ab[0] ? (b == nb - 1) : xack[b]);
      end
    end
    exp_turns = 0;
    prev = 1'b0;
    foreach (owners[i]) begin
      if (owners[i] != prev) exp_turns++;
      prev = owners[i];
    end
    if (prev != 1'b0) exp_turns++;
  endtask

  task automatic bus_start(input bit exp_de, input string tag);
    sda_m = 1'b1; sda_s = 1'b1;
    clk_n(HALF / 2);
    scl = 1'b1;
    clk_n(HALF / 2);
    sda_m = 1'b0; sda_s = 1'b0;
    clk_n(2);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL %s start busy: got %b expected 1", tag, busy); end
    checks++; if (dir !== 1'b0) begin errors++; $display("FAIL %s start dir: got %b expected 0", tag, dir); end
    checks++; if (bcnt !== 4'd0) begin errors++; $display("FAIL %s start bit_cnt: got %0d expected 0", tag, bcnt); end
    checks++; if (de !== exp_de) begin errors++; $display("FAIL %s start drive_en: got %b expected %b", tag, de, exp_de); end
    clk_n(HALF);
  endtask

  task automatic bus_stop(input string tag);
    scl = 1'b0;
    clk_n(HALF / 2);
    sda_m = 1'b0; sda_s = 1'b0;
    clk_n(HALF / 2);
    scl = 1'b1;
    clk_n(HALF / 2);
    sda_m = 1'b1; sda_s = 1'b1;
    clk_n(2);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s stop busy: got %b expected 0", tag, busy); end
    checks++; if (dir !== 1'b0) begin errors++; $display("FAIL %s stop dir: got %b expected 0", tag, dir); end
    checks++; if (bcnt !== 4'd0) begin errors++; $display("FAIL %s stop bit_cnt: got %0d expected 0", tag, bcnt); end
    checks++; if (abort !== 1'b0) begin errors++; $display("FAIL %s stop abort: got %b expected 0", tag, abort); end
    checks++; if (de !== 1'b1) begin errors++; $display("FAIL %s stop drive_en: got %b expected 1", tag, de); end
    clk_n(HALF);
  endtask

  task automatic send_bit(input bit v, input bit own, input bit prev, input int cnt, input string tag);
    scl = 1'b0;
    clk_n(2);
    checks++; if (dir !== own) begin errors++; $display("FAIL %s fall dir bit%0d: got %b expected %b", tag, cnt, dir, own); end
    checks++; if (de !== (own == prev)) begin errors++; $display("FAIL %s fall drive_en bit%0d: got %b expected %b", tag, cnt, de, own == prev); end
    sda_m = v; sda_s = v;
    clk_n(HALF - 2);
    scl = 1'b1;
    clk_n(HALF / 2);
    checks++; if (dir !== own) begin errors++; $display("FAIL %s high dir bit%0d: got %b expected %b", tag, cnt, dir, own); end
    checks++; if (de !== 1'b1) begin errors++; $display("FAIL %s high drive_en bit%0d: got %b expected 1", tag, cnt, de); end
    checks++; if (bcnt !== 4'(cnt)) begin errors++; $display("FAIL %s high bit_cnt: got %0d expected %0d", tag, bcnt, cnt); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL %s high busy bit%0d: got %b expected 1", tag, cnt, busy); end
    clk_n(HALF / 2);
  endtask

  task automatic run_bits(input int limit, input bit finish, input string tag);
    bit prev = 1'b0;
    for (int i = 0; i < limit; i++) begin
      send_bit(vals[i], owners[i], prev, i % 9, tag);
      prev = owners[i];
    end
    if (finish) begin
      scl = 1'b0;
      clk_n(2);
      checks++; if (dir !== 1'b0) begin errors++; $display("FAIL %s end dir: got %b expected 0", tag, dir); end
      checks++; if (de !== (prev == 1'b0)) begin errors++; $display("FAIL %s end drive_en: got %b expected %b", tag, de, prev == 1'b0); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL %s end busy: got %b expected 1", tag, busy); end
      checks++; if (bcnt !== 4'd0) begin errors++; $display("FAIL %s end bit_cnt: got %0d expected 0", tag, bcnt); end
      clk_n(HALF - 2);
    end
  endtask

  task automatic check_turns(input int n, input string tag);
    int bad = 0;
    checks++;
    if (turn_log.size() != n) begin
      errors++; $display("FAIL %s turn count: got %0d expected %0d", tag, turn_log.size(), n);
    end
    foreach (turn_log[i]) if (turn_log[i] != F_REF_TURN) bad++;
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL %s turn length: %0d of %0d gaps differ from %0d ref edges", tag, bad, turn_log.size(), F_REF_TURN);
    end
    turn_log.delete();
  endtask

  task automatic test_reset;
    #3;
    checks++; if ({dir, de, busy, abort, bcnt} !== 8'h00) begin errors++; $display("FAIL reset outputs: got %b expected 00000000", {dir, de, busy, abort, bcnt}); end
    clk_n(3);
    checks++; if ({dir, de, busy, abort, bcnt} !== 8'h00) begin errors++; $display("FAIL reset held: got %b expected 00000000", {dir, de, busy, abort, bcnt}); end
    rstn = 1'b1;
    clk_n(1);
    checks++; if (de !== 1'b1) begin errors++; $display("FAIL reset idle drive_en: got %b expected 1", de); end
    checks++; if (dir !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL reset idle dir/busy: got %b%b expected 00", dir, busy); end
    clk_n(5);
    turn_log.delete();
  endtask

  task automatic test_write;
    xdata[0] = 8'hA5; xack[0] = 1'b0;
    build_xfer(8'hA0, 1'b0, 1);
    bus_start(1'b1, "write");
    run_bits(owners.size(), 1'b1, "write");
    bus_stop("write");
    check_turns(exp_turns, "write");
  endtask

  task automatic test_read;
    xdata[0] = 8'h3C; xdata[1] = 8'hC3;
    build_xfer(8'hA1, 1'b0, 2);
    bus_start(1'b1, "read");
    run_bits(owners.size(), 1'b1, "read");
    bus_stop("read");
    check_turns(exp_turns, "read");
  endtask

  task automatic test_addr_nack;
    build_xfer(8'h44, 1'b1, 0);
    bus_start(1'b1, "nack");
    run_bits(owners.size(), 1'b1, "nack");
    clk_n(2 * HALF);
    checks++; if (busy !== 1'b1 || dir !== 1'b0) begin errors++; $display("FAIL nack wait_stop busy/dir: got %b%b expected 10", busy, dir); end
    bus_stop("nack");
    check_turns(exp_turns, "nack");
  endtask

  task automatic test_restart;
    int pre_turns = 0;
    bit prev = 1'b0;
    xdata[0] = 8'($urandom);
    build_xfer(8'hA1, 1'b0, 1);
    for (int i = 0; i < 13; i++) begin
      if (owners[i] != prev) pre_turns++;
      prev = owners[i];
    end
    if (prev != 1'b0) pre_turns++;
    bus_start(1'b1, "restart");
    run_bits(13, 1'b0, "restart");
    scl = 1'b0;
    clk_n(2);
    checks++; if (bcnt !== 4'd4 || dir !== 1'b1) begin errors++; $display("FAIL restart pre bit_cnt/dir: got %0d/%b expected 4/1", bcnt, dir); end
    bus_start(1'b0, "restart2");
    xdata[0] = 8'($urandom); xack[0] = 1'($urandom);
    build_xfer(8'hA0, 1'b0, 1);
    run_bits(owners.size(), 1'b1, "restart2");
    bus_stop("restart");
    check_turns(pre_turns + exp_turns, "restart");
  endtask

  task automatic test_abort;
    xdata[0] = 8'h96; xack[0] = 1'b0;
    build_xfer(8'hA0, 1'b0, 1);
    bus_start(1'b1, "abort");
    run_bits(9, 1'b0, "abort");
    scl = 1'b0;
    clk_n(2);
    mm_s = 1'b1;
    clk_n(1);
    mm_s = 1'b0;
    clk_n(1);
    checks++; if (abort !== 1'b0 || de !== 1'b0) begin errors++; $display("FAIL abort in turnaround: got abort=%b de=%b expected 0 0", abort, de); end
    clk_n(HALF - 4);
    sda_m = xdata[0][7]; sda_s = xdata[0][7];
    scl = 1'b1;
    clk_n(HALF / 2);
    mm_m = 1'b1;
    clk_n(1);
    mm_m = 1'b0;
    clk_n(1);
    checks++; if (abort !== 1'b0 || de !== 1'b1) begin errors++; $display("FAIL abort wrong side: got abort=%b de=%b expected 0 1", abort, de); end
    mm_s = 1'b1;
    clk_n(1);
    mm_s = 1'b0;
    checks++; if (abort !== 1'b1 || de !== 1'b0) begin errors++; $display("FAIL abort hit: got abort=%b de=%b expected 1 0", abort, de); end
    clk_n(4);
    checks++; if (abort !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL abort hold: got abort=%b busy=%b expected 1 1", abort, busy); end
    bus_stop("abort");
    turn_log.delete();
  endtask

  task automatic test_reset_mid;
    xdata[0] = 8'h5A;
    build_xfer(8'hA1, 1'b0, 1);
    bus_start(1'b1, "rstmid");
    run_bits(12, 1'b0, "rstmid");
    #2 rstn = 1'b0;
    #1;
    checks++; if ({dir, de, busy, abort, bcnt} !== 8'h00) begin errors++; $display("FAIL rstmid outputs: got %b expected 00000000", {dir, de, busy, abort, bcnt}); end
    clk_n(3);
    scl = 1'b1; sda_m = 1'b1; sda_s = 1'b1;
    clk_n(2);
    rstn = 1'b1;
    clk_n(HALF);
    turn_log.delete();
    xdata[0] = 8'($urandom); xack[0] = 1'b0;
    build_xfer(8'hA0, 1'b0, 1);
    bus_start(1'b1, "rstwr");
    run_bits(owners.size(), 1'b1, "rstwr");
    bus_stop("rstwr");
    check_turns(exp_turns, "rstwr");
  endtask

  task automatic test_random;
    logic [7:0] ab;
    bit anack;
    int nb;
    for (int t = 0; t < 6; t++) begin
      ab    = 8'($urandom);
      anack = ($urandom_range(0, 3) == 0);
      nb    = $urandom_range(1, 3);
      for (int b = 0; b < 4; b++) begin
        xdata[b] = 8'($urandom);
        xack[b]  = 1'($urandom);
      end
      build_xfer(ab, anack, nb);
      bus_start(1'b1, "random");
      run_bits(owners.size(), 1'b1, "random");
      bus_stop("random");
      check_turns(exp_turns, "random");
    end
  endtask

  initial begin
    test_reset;
    test_write;
    test_read;
    test_addr_nack;
    test_restart;
    test_abort;
    test_reset_mid;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
